// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_frame_rx
//  Purpose  : Bit-serial frame receiver, one sample per clock, configurable
//             data width, optional even/odd parity, 1 or 2 stop bits, with a
//             valid/ready output register and framing/parity/overrun pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_frame_rx #(
  parameter int DATA_BITS = 8,   // 5..16, LSB first
  parameter int PARITY    = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS = 1    // 1 or 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int                CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic              LAST_STOP = (STOP_BITS == 2);
  localparam logic              ODD       = (PARITY == 2);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    PAR  = 3'd2,
    STOP = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
  logic                 stop_cnt, stop_cnt_n;
  logic                 par_bit, par_bit_n;

  logic                 frame_done;   // all stop bits sampled as 1 this cycle
  logic                 stop_bad;     // a stop bit sampled as 0 this cycle
  logic                 parity_ok;
  logic                 good;
  logic                 accept;
  logic                 load;

  logic [DATA_BITS-1:0] out_data_n;
  logic                 out_valid_n;
  logic                 frame_err_n;
  logic                 parity_err_n;
  logic                 overrun_n;

  // Register all state, datapath and output flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      par_bit    <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      stop_cnt   <= stop_cnt_n;
      par_bit    <= par_bit_n;
      out_data   <= out_data_n;
      out_valid  <= out_valid_n;
      frame_err  <= frame_err_n;
      parity_err <= parity_err_n;
      overrun    <= overrun_n;
    end
  end

  // Next-state, frame checking and output-register handshake.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    par_bit_n  = par_bit;
    frame_done = 1'b0;
    stop_bad   = 1'b0;

    case (state)
      IDLE: begin
        if (!in) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        shreg_n = {in, shreg[DATA_BITS-1:1]};
        if (bit_cnt == LAST_BIT) begin
          bit_cnt_n  = '0;
          stop_cnt_n = 1'b0;
          state_n    = (PARITY != 0) ? PAR : STOP;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      PAR: begin
        par_bit_n = in;
        state_n   = STOP;
      end
      STOP: begin
        if (!in) begin
          // Remaining stop bits are not waited for once one is bad.
          stop_bad   = 1'b1;
          stop_cnt_n = 1'b0;
          state_n    = ERR;
        end else if (stop_cnt == LAST_STOP) begin
          frame_done = 1'b1;
          stop_cnt_n = 1'b0;
          state_n    = IDLE;
        end else begin
          stop_cnt_n = 1'b1;
        end
      end
      ERR: begin
        // A line held low after a framing error must not look like a start bit.
        if (in) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    parity_ok = (PARITY == 0) ? 1'b1 : ((^{shreg, par_bit}) == ODD);
    good      = frame_done & parity_ok;
    accept    = out_valid & out_ready;
    load      = good & (~out_valid | out_ready);

    out_data_n   = load ? shreg : out_data;
    out_valid_n  = load ? 1'b1 : (accept ? 1'b0 : out_valid);
    frame_err_n  = stop_bad;
    parity_err_n = frame_done & ~parity_ok;
    overrun_n    = good & ~load;
  end

endmodule
`default_nettype wire
